// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ifetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries with flush; the head is read
// straight from registered storage, so a push is visible one cycle later.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues in-order fetches, tracks in-flight words,
// drops stale responses after a redirect. Define IFETCH_PERF_EN for perf counters.
module ifetch_prefetch_buffer
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_empty_cycles,
  output logic [31:0] perf_flushes
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          misalign_q, misalign_d;

  logic [CW-1:0] occ;
  logic [CW:0]   inflight;
  logic          fire, rsp, push, pop;
  fetch_entry_t  push_entry, head;

  assign inflight = {1'b0, occ} + {1'b0, outst_q};
  // Gated with the reset pin so the request is low for the whole reset window.
  assign imem_req  = reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign fire      = imem_req && imem_gnt;
  assign rsp       = imem_rvalid && (outst_q != '0);
  assign push      = rsp && (discard_q == '0) && !redirect_valid;
  assign pop       = instr_valid && instr_ready && !redirect_valid;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = resp_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    outst_d    = outst_q - CW'(rsp) + CW'(fire);
    misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      discard_d  = outst_q - CW'(rsp);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (rsp) begin
        if (discard_q != '0) discard_d = discard_q - CW'(1);
        else                 resp_pc_d = resp_pc_q + PC_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      misalign_q <= misalign_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .clear_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (instr_valid),
    .count_o     (occ)
  );

  assign instr_out        = head.instr;
  assign instr_pc         = head.pc;
  assign fetch_misaligned = misalign_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_empty_q, perf_flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_empty_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (!instr_valid && instr_ready) perf_empty_q <= perf_empty_q + 32'd1;
      if (redirect_valid)              perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_empty_cycles = perf_empty_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Self-checking bench: in-order memory model with variable latency plus a
// scoreboard of expected {pc, instr} reloaded on every reset and redirect.
module tb_ifetch_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;

  ifetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_out        (instr_out),
    .instr_pc         (instr_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  sb_t         exp_q[$];
  mem_t        pipe_q[$];
  sb_t         e;
  mem_t        m;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          grant_cnt = 0;
  int          mem_lat = 1;
  logic [31:0] exp_addr = '0;
  logic [31:0] held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reload_exp(input logic [31:0] pc);
    logic [31:0] p;
    p = {pc[31:2], 2'b00};
    exp_addr = p;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{p, mem_word(p)});
      p = p + 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    reload_exp(pc);
  endtask

  task automatic wait_valid(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < max_cyc);
    check_val("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  // Memory model, grant-address check and delivery scoreboard, all at negedge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      pipe_q.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      imem_rvalid = 1'b0;
      if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
        m = pipe_q.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m.addr);
      end
      if (imem_req && imem_gnt) begin
        check_val("gnt_addr", imem_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        grant_cnt++;
        pipe_q.push_back('{imem_addr, cyc + mem_lat});
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_val("pop_pc", instr_pc, e.pc);
          check_val("pop_instr", instr_out, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_req", 32'(imem_req), 32'd0);
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_instr", instr_out, 32'd0);
    check_val("rst_pc", instr_pc, 32'd0);
    check_val("rst_misal", 32'(fetch_misaligned), 32'd0);

    // Streaming from RESET_PC with 1-cycle memory
    reload_exp(RESET_PC);
    step();
    reset = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    check_val("t1_req", 32'(imem_req), 32'd1);
    check_val("t1_addr", imem_addr, RESET_PC);
    check_val("t1_valid_c0", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check_val("t1_valid_c1", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check_val("t1_valid_c2", 32'(instr_valid), 32'd1);
    check_val("t1_first_pc", instr_pc, RESET_PC);
    repeat (20) @(negedge clk);

    // Back-pressure: exactly DEPTH grants, then one pop frees one slot
    step();
    instr_ready = 1'b0;
    start_redirect(32'h0);
    step();
    redirect_valid = 1'b0;
    grant_cnt = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_val("t2_grants", 32'(grant_cnt), 32'd4);
    check_val("t2_req_stall", 32'(imem_req), 32'd0);
    check_val("t2_head_pc", instr_pc, 32'h0);
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    check_val("t2_req_after_pop", 32'(imem_req), 32'd1);
    check_val("t2_addr_after_pop", imem_addr, 32'h10);
    step();
    instr_ready = 1'b1;
    repeat (10) @(negedge clk);

    // Address held without grant, then 3 in flight dropped by a redirect
    step();
    imem_gnt = 1'b0;
    @(negedge clk);
    held = imem_addr;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("t3_addr_hold", imem_addr, held);
    end
    mem_lat = 5;
    step();
    start_redirect(32'h200);
    step();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    start_redirect(32'h100);
    step();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    mem_lat = 1;
    wait_valid(40);
    check_val("t3_pc", instr_pc, 32'h100);
    check_val("t3_instr", instr_out, mem_word(32'h100));
    repeat (8) @(negedge clk);

    // Misaligned redirect
    step();
    start_redirect(32'h102);
    @(negedge clk);
    check_val("t4_req_redir", 32'(imem_req), 32'd0);
    check_val("t4_misal_n", 32'(fetch_misaligned), 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_val("t4_misal_n1", 32'(fetch_misaligned), 32'd1);
    check_val("t4_addr", imem_addr, 32'h100);
    check_val("t4_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    check_val("t4_misal_n2", 32'(fetch_misaligned), 32'd0);
    repeat (8) @(negedge clk);

    // Redirect coinciding with rvalid and pop
    step();
    start_redirect(32'h300);
    @(negedge clk);
    check_val("t5_valid_pre", 32'(instr_valid), 32'd1);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_val("t5_flushed", 32'(instr_valid), 32'd0);
    wait_valid(20);
    check_val("t5_pc", instr_pc, 32'h300);
    check_val("t5_instr", instr_out, mem_word(32'h300));
    repeat (6) @(negedge clk);

    // PC wrap across 0xFFFF_FFFC
    step();
    start_redirect(32'hFFFF_FFF8);
    step();
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);

    // Reset with two fetches in flight and fetch_pc at 0x40
    step();
    imem_gnt = 1'b0;
    mem_lat = 4;
    start_redirect(32'h38);
    step();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    check_val("t6_fetch_pc", imem_addr, 32'h40);
    reset = 1'b0;
    #1;
    check_val("t6_req", 32'(imem_req), 32'd0);
    check_val("t6_valid", 32'(instr_valid), 32'd0);
    check_val("t6_instr", instr_out, 32'd0);
    check_val("t6_pc", instr_pc, 32'd0);
    check_val("t6_misal", 32'(fetch_misaligned), 32'd0);
    check_val("t6_addr", imem_addr, RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 1;
    reload_exp(RESET_PC);
    reset = 1'b1;
    imem_gnt = 1'b1;
    @(negedge clk);
    check_val("t6_restart_req", 32'(imem_req), 32'd1);
    check_val("t6_restart_addr", imem_addr, RESET_PC);
    wait_valid(10);
    check_val("t6_restart_pc", instr_pc, RESET_PC);
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
